mac_lookup_ctrl: RTL and testbench
==================================

Name: mac_lookup_ctrl

Overview:
- Requester side of the MAC table interface: parses the DA/SA header of each ingress frame from a byte stream.
- Hashes DA and SA into table indices, drives the learn write and lookup, captures the registered port result.
- Issues one forwarding decision per frame (unicast port, flood, or drop) to the pre-arbiters over a valid/ready handshake.

Parameters:
- pPORT_NUM, 4, number of switch ports; port field width PW = $clog2(pPORT_NUM)
- pMAC_MEM_DEPTH, 1024, MAC table depth; index width IW = $clog2(pMAC_MEM_DEPTH)
- pHDR_BYTES, 12, header bytes consumed per frame (DA 6 then SA 6, MSB byte first)

Ports:
- iclk  input  1  clock
- irst_n  input  1  reset, synchronous, active-low
- i_valid  input  1  ingress byte valid
- i_sof  input  1  first byte of frame, qualified by i_valid
- i_data  input  8  ingress byte
- i_src_port  input  PW  ingress port of current frame, sampled with i_sof byte
- o_ready  output  1  byte accepted when i_valid && o_ready
- o_write_enable  output  1  learn strobe to MAC table
- o_port_num  output  PW  learned port (source port)
- o_MAC_SA  output  IW  hashed SA index
- o_MAC_DA  output  IW  hashed DA index
- i_port_lookup  input  PW  registered table read result
- o_dec_valid  output  1  decision valid
- i_dec_ready  input  1  decision accepted
- o_dec_port  output  PW  destination port
- o_dec_flood  output  1  send to all ports except source
- o_dec_drop  output  1  destination equals source; discard

Behaviour:
- Reset: one clock and one reset only; reset is synchronous, active-low (irst_n sampled on posedge iclk). All outputs 0, byte counter 0, state IDLE. Reset mid-frame or mid-decision aborts silently; no write is issued afterwards.
- FSM states: IDLE, COLLECT, LOOKUP, WAIT, DECIDE.
- IDLE: o_ready=1. Bytes without i_sof are discarded (payload drain). Byte with i_sof: store as DA byte 0, latch i_src_port, count=1, go to COLLECT.
- COLLECT: o_ready=1. Each accepted byte is shifted into the DA (bytes 0-5) or SA (bytes 6-11) register.
- COLLECT, i_sof: an accepted byte with i_sof restarts the header; it becomes byte 0 (count=1) and i_src_port is relatched.
- COLLECT, byte 11: on acceptance of byte pHDR_BYTES-1 (cycle T), go to LOOKUP.
- i_valid low stalls collection with no timeout.
- LOOKUP (cycle T+1): o_ready=0. o_write_enable=1 for exactly this cycle. o_port_num = latched source port; o_MAC_SA and o_MAC_DA are driven from registers. Go to WAIT.
- WAIT (T+2): o_write_enable=0. Capture i_port_lookup at end of cycle. Go to DECIDE.
- DECIDE: o_dec_valid=1 from T+3.
  - o_dec_flood=1 if DA bit 40 (I/G bit, LSB of DA byte 0) is set, which also covers broadcast.
  - Otherwise o_dec_port = captured lookup.
  - o_dec_drop=1 iff not flood and lookup == source port. flood and drop are never both 1.
  - Outputs hold stable while o_dec_valid && !i_dec_ready. On handshake, return to IDLE next cycle with o_dec_valid=0.
- Same-index case: if hash(SA)==hash(DA), the lookup returns the pre-write entry, because the table reads old data on a same-cycle write. That result is used unchanged.
- Hash: zero-extend the 48-bit MAC to a multiple of IW. XOR all IW-bit slices, LSB slice first. Purely combinational, registered into o_MAC_*.
- Unlearned entries read as port 0; this is forwarded as unicast to port 0 (no valid bit exists in the table).
- Throughput: one frame per 12 + 3 cycles minimum; back-to-back sof is accepted in the IDLE cycle following the handshake.

Test Plan:
- Basic learn/lookup: frame from port 2, DA=00:00:00:00:00:07, SA=00:00:00:00:00:05, table returns 3 -> o_write_enable=1 one cycle with o_MAC_SA=5, o_MAC_DA=7, o_port_num=2. o_dec_valid at T+3 with port=3, flood=0, drop=0.
- Broadcast DA FF:FF:FF:FF:FF:FF from port 1 -> flood=1, drop=0. Learn still issued with the SA index.
- Same-port drop: src port 1, table returns 1, unicast DA -> drop=1.
- Backpressure: i_dec_ready held low 5 cycles -> o_dec_valid and all decision fields stable; o_ready=0. Handshake returns to IDLE next cycle.
- Restart/stall: i_sof reasserted at header byte 4, i_valid gaps inserted -> header rebuilt from new sof. Exactly one write and one decision.
- Reset mid-WAIT: irst_n low one cycle -> all outputs 0 next cycle, no o_dec_valid, next frame processed normally.

Source files
------------

// File: rtl/mac_lookup_if.sv
// Signals between the MAC lookup controller and its neighbours: the ingress
// byte stream, the MAC table request/result, and the forwarding decision.
interface mac_lookup_if #(
    parameter int pPORT_NUM      = 4,
    parameter int pMAC_MEM_DEPTH = 1024
);
    localparam int PW = $clog2(pPORT_NUM);
    localparam int IW = $clog2(pMAC_MEM_DEPTH);

    logic          i_valid;
    logic          i_sof;
    logic [7:0]    i_data;
    logic [PW-1:0] i_src_port;
    logic          o_ready;
    logic          o_write_enable;
    logic [PW-1:0] o_port_num;
    logic [IW-1:0] o_MAC_SA;
    logic [IW-1:0] o_MAC_DA;
    logic [PW-1:0] i_port_lookup;
    logic          o_dec_valid;
    logic          i_dec_ready;
    logic [PW-1:0] o_dec_port;
    logic          o_dec_flood;
    logic          o_dec_drop;

    // controller side
    modport slave (
        input  i_valid, i_sof, i_data, i_src_port, i_port_lookup, i_dec_ready,
        output o_ready, o_write_enable, o_port_num, o_MAC_SA, o_MAC_DA,
        output o_dec_valid, o_dec_port, o_dec_flood, o_dec_drop
    );

    // ingress / table / arbiter side
    modport master (
        output i_valid, i_sof, i_data, i_src_port, i_port_lookup, i_dec_ready,
        input  o_ready, o_write_enable, o_port_num, o_MAC_SA, o_MAC_DA,
        input  o_dec_valid, o_dec_port, o_dec_flood, o_dec_drop
    );
endinterface

// File: rtl/mac_lookup_ctrl.sv
// MAC table requester: collects DA/SA from the ingress byte stream, hashes
// them into table indices, issues learn + lookup, and hands one forwarding
// decision per frame to the pre-arbiters. All outputs are registered.
module mac_lookup_ctrl #(
    parameter int pPORT_NUM      = 4,
    parameter int pMAC_MEM_DEPTH = 1024,
    parameter int pHDR_BYTES     = 12
) (
    input logic        iclk,
    input logic        irst_n,
    mac_lookup_if.slave bus
);
    localparam int PW       = $clog2(pPORT_NUM);
    localparam int IW       = $clog2(pMAC_MEM_DEPTH);
    localparam int CW       = $clog2(pHDR_BYTES + 1);
    localparam int DA_BYTES = 6;
    localparam int NSL      = (48 + IW - 1) / IW;

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_LOOKUP, S_WAIT, S_DECIDE} state_t;

    // XOR-fold of the zero-extended MAC into IW-bit slices
    function automatic logic [IW-1:0] mac_hash(input logic [47:0] mac);
        logic [NSL*IW-1:0] ext;
        logic [IW-1:0]     h;
        ext       = '0;
        ext[47:0] = mac;
        h         = '0;
        for (int s = 0; s < NSL; s++) h = h ^ ext[s*IW +: IW];
        return h;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [47:0]   da_q, da_d, sa_q, sa_d;
    logic [PW-1:0] src_q, src_d;
    logic          ready_q, ready_d;
    logic          we_q, we_d;
    logic [PW-1:0] port_num_q, port_num_d;
    logic [IW-1:0] mac_sa_q, mac_sa_d, mac_da_q, mac_da_d;
    logic          dec_valid_q, dec_valid_d;
    logic [PW-1:0] dec_port_q, dec_port_d;
    logic          dec_flood_q, dec_flood_d;
    logic          dec_drop_q, dec_drop_d;
    logic          accept;

    assign accept = bus.i_valid && ready_q;

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            da_q        <= '0;
            sa_q        <= '0;
            src_q       <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            port_num_q  <= '0;
            mac_sa_q    <= '0;
            mac_da_q    <= '0;
            dec_valid_q <= 1'b0;
            dec_port_q  <= '0;
            dec_flood_q <= 1'b0;
            dec_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            da_q        <= da_d;
            sa_q        <= sa_d;
            src_q       <= src_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            port_num_q  <= port_num_d;
            mac_sa_q    <= mac_sa_d;
            mac_da_q    <= mac_da_d;
            dec_valid_q <= dec_valid_d;
            dec_port_q  <= dec_port_d;
            dec_flood_q <= dec_flood_d;
            dec_drop_q  <= dec_drop_d;
        end
    end

    // next-state: header collection, learn/lookup issue, decision handshake
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        da_d        = da_q;
        sa_d        = sa_q;
        src_d       = src_q;
        ready_d     = ready_q;
        we_d        = 1'b0;
        port_num_d  = port_num_q;
        mac_sa_d    = mac_sa_q;
        mac_da_d    = mac_da_q;
        dec_valid_d = dec_valid_q;
        dec_port_d  = dec_port_q;
        dec_flood_d = dec_flood_q;
        dec_drop_d  = dec_drop_q;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                ready_d = 1'b1;
                if (accept && bus.i_sof) begin
                    // sof always (re)starts the header at DA byte 0
                    da_d    = {da_q[39:0], bus.i_data};
                    src_d   = bus.i_src_port;
                    cnt_d   = CW'(1);
                    state_d = S_COLLECT;
                end else if (accept && state_q == S_COLLECT) begin
                    if (cnt_q < CW'(DA_BYTES)) da_d = {da_q[39:0], bus.i_data};
                    else                       sa_d = {sa_q[39:0], bus.i_data};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(pHDR_BYTES - 1)) begin
                        // last header byte: present learn + lookup next cycle
                        state_d    = S_LOOKUP;
                        ready_d    = 1'b0;
                        cnt_d      = '0;
                        we_d       = 1'b1;
                        port_num_d = src_q;
                        mac_da_d   = mac_hash(da_d);
                        mac_sa_d   = mac_hash(sa_d);
                    end
                end
            end
            S_LOOKUP: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // table read is registered; result is valid this cycle
                dec_valid_d = 1'b1;
                dec_flood_d = da_q[40];
                dec_port_d  = bus.i_port_lookup;
                dec_drop_d  = !da_q[40] && (bus.i_port_lookup == src_q);
                state_d     = S_DECIDE;
            end
            S_DECIDE: begin
                if (bus.i_dec_ready) begin
                    dec_valid_d = 1'b0;
                    dec_port_d  = '0;
                    dec_flood_d = 1'b0;
                    dec_drop_d  = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_ready        = ready_q;
    assign bus.o_write_enable = we_q;
    assign bus.o_port_num     = port_num_q;
    assign bus.o_MAC_SA       = mac_sa_q;
    assign bus.o_MAC_DA       = mac_da_q;
    assign bus.o_dec_valid    = dec_valid_q;
    assign bus.o_dec_port     = dec_port_q;
    assign bus.o_dec_flood    = dec_flood_q;
    assign bus.o_dec_drop     = dec_drop_q;
endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Bench for mac_lookup_ctrl: a registered-read MAC table environment plus a
// behavioural model (bitwise hash fold, reference table array) that predicts
// learn indices and forwarding decisions for directed and random frames.
module tb_mac_lookup_ctrl;
    localparam int PN = 4, DEPTH = 1024, PW = 2, IW = 10;

    logic iclk = 1'b0;
    logic irst_n = 1'b0;
    always #5 iclk = ~iclk;

    mac_lookup_if #(.pPORT_NUM(PN), .pMAC_MEM_DEPTH(DEPTH)) bus ();

    mac_lookup_ctrl #(.pPORT_NUM(PN), .pMAC_MEM_DEPTH(DEPTH), .pHDR_BYTES(12)) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .bus   (bus)
    );

    // MAC table: registered read, old data on a same-cycle write
    bit [PW-1:0] tbl [DEPTH];
    always @(posedge iclk) begin
        bus.i_port_lookup <= tbl[bus.o_MAC_DA];
        if (bus.o_write_enable) tbl[bus.o_MAC_SA] <= bus.o_port_num;
    end

    int wr_cnt = 0, dec_cnt = 0;
    always @(posedge iclk) begin
        if (bus.o_write_enable) wr_cnt <= wr_cnt + 1;
        if (bus.o_dec_valid && bus.i_dec_ready) dec_cnt <= dec_cnt + 1;
    end

    int n_chk = 0, n_fail = 0;
    bit [PW-1:0] ref_tbl [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bit j of the MAC lands on index bit j mod IW
    function automatic logic [IW-1:0] ref_hash(input logic [47:0] m);
        logic [IW-1:0] h;
        h = '0;
        for (int j = 0; j < 48; j++) h[j % IW] = h[j % IW] ^ m[j];
        return h;
    endfunction

    // called at a negedge; returns at the negedge after acceptance
    task automatic put_byte(input logic [7:0] b, input logic sof, input logic [PW-1:0] src, input int gap);
        int n;
        if (gap > 0) repeat ($urandom_range(0, gap)) begin
            bus.i_valid = 1'b0;
            bus.i_data  = 8'($urandom);
            @(negedge iclk);
        end
        bus.i_valid = 1'b1; bus.i_sof = sof; bus.i_data = b; bus.i_src_port = src;
        n = 0;
        while (!bus.o_ready && n < 50) begin @(negedge iclk); n++; end
        chk("ready_wait", bus.o_ready, 1);
        @(negedge iclk);
        bus.i_valid = 1'b0; bus.i_sof = 1'b0;
    endtask

    task automatic send_hdr(input logic [47:0] da, sa, input logic [PW-1:0] src, input int gap, input int restart_at);
        put_byte(8'($urandom), 1'b0, src, gap);   // payload drain in IDLE
        for (int k = 0; k < restart_at; k++) put_byte(8'($urandom), k == 0, src ^ 2'd1, gap);
        for (int k = 0; k < 12; k++)
            put_byte(k < 6 ? da[47-8*k -: 8] : sa[47-8*(k-6) -: 8], k == 0, src, gap);
    endtask

    task automatic chk_dec(input string tag, input logic [PW-1:0] port, input logic fl, input logic dr);
        chk({tag, "_valid"}, bus.o_dec_valid, 1);
        chk({tag, "_flood"}, bus.o_dec_flood, fl);
        chk({tag, "_drop"}, bus.o_dec_drop, dr);
        if (!fl) chk({tag, "_port"}, bus.o_dec_port, port);
    endtask

    task automatic do_frame(input string tag, input logic [47:0] da, sa, input logic [PW-1:0] src,
                            input int gap, input int bp, input int restart_at);
        logic [IW-1:0] hd, hs;
        logic [PW-1:0] look;
        logic fl, dr;
        int w0, d0;
        w0 = wr_cnt; d0 = dec_cnt;
        hd = ref_hash(da); hs = ref_hash(sa);
        look = ref_tbl[hd];
        fl = da[40];
        dr = !fl && (look == src);
        ref_tbl[hs] = src;
        send_hdr(da, sa, src, gap, restart_at);
        // T+1: learn/lookup strobe
        chk({tag, "_we"}, bus.o_write_enable, 1);
        chk({tag, "_sa_idx"}, bus.o_MAC_SA, hs);
        chk({tag, "_da_idx"}, bus.o_MAC_DA, hd);
        chk({tag, "_port_num"}, bus.o_port_num, src);
        chk({tag, "_ready_lk"}, bus.o_ready, 0);
        @(negedge iclk);
        // T+2
        chk({tag, "_we_off"}, bus.o_write_enable, 0);
        chk({tag, "_nodec"}, bus.o_dec_valid, 0);
        @(negedge iclk);
        // T+3 onward: decision held under backpressure
        chk_dec(tag, look, fl, dr);
        for (int c = 0; c < bp; c++) begin
            @(negedge iclk);
            chk_dec({tag, "_bp"}, look, fl, dr);
            chk({tag, "_bp_ready"}, bus.o_ready, 0);
        end
        bus.i_dec_ready = 1'b1;
        @(negedge iclk);
        bus.i_dec_ready = 1'b0;
        chk({tag, "_dec_done"}, bus.o_dec_valid, 0);
        chk({tag, "_idle_ready"}, bus.o_ready, 1);
        chk({tag, "_one_write"}, wr_cnt, w0 + 1);
        chk({tag, "_one_dec"}, dec_cnt, d0 + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, bus.o_ready, 0);
        chk({tag, "_we"}, bus.o_write_enable, 0);
        chk({tag, "_port_num"}, bus.o_port_num, 0);
        chk({tag, "_sa"}, bus.o_MAC_SA, 0);
        chk({tag, "_da"}, bus.o_MAC_DA, 0);
        chk({tag, "_dvalid"}, bus.o_dec_valid, 0);
        chk({tag, "_dport"}, bus.o_dec_port, 0);
        chk({tag, "_dflood"}, bus.o_dec_flood, 0);
        chk({tag, "_ddrop"}, bus.o_dec_drop, 0);
    endtask

    initial begin
        logic [47:0]   da, sa, learned[$];
        logic [PW-1:0] src, lsrc[$];
        int d0, idx;
        bus.i_valid = 1'b0; bus.i_sof = 1'b0; bus.i_data = '0;
        bus.i_src_port = '0; bus.i_dec_ready = 1'b0;
        repeat (3) @(negedge iclk);
        chk_all_zero("reset");
        irst_n = 1'b1;
        @(negedge iclk);

        // learn DA 07 -> port 3 first so the basic lookup returns 3
        do_frame("learn7", 48'h9, 48'h7, 2'd3, 0, 0, 0);
        do_frame("basic", 48'h7, 48'h5, 2'd2, 0, 0, 0);
        do_frame("bcast", 48'hFFFF_FFFF_FFFF, 48'hA1, 2'd1, 0, 0, 0);
        do_frame("drop", 48'hA1, 48'h33, 2'd1, 0, 0, 0);
        do_frame("backpr", 48'h5, 48'h44, 2'd0, 0, 5, 0);
        do_frame("restart", 48'h0000_0000_0033, 48'h0102_0304_0506, 2'd2, 2, 0, 4);
        // hash(00..1400) == hash(5): lookup sees the entry before the learn
        do_frame("sameidx", 48'h1400, 48'h5, 2'd3, 0, 0, 0);

        // reset while in WAIT: the learn already went out, no decision follows
        d0 = dec_cnt;
        ref_tbl[ref_hash(48'h77)] = 2'd2;
        send_hdr(48'h5, 48'h77, 2'd2, 0, 0);
        chk("rst_we", bus.o_write_enable, 1);
        @(negedge iclk);
        irst_n = 1'b0;
        @(negedge iclk);
        irst_n = 1'b1;
        chk_all_zero("rst_mid");
        repeat (4) @(negedge iclk);
        chk("rst_no_dec", dec_cnt, d0);
        chk("rst_no_dvalid", bus.o_dec_valid, 0);
        do_frame("post_rst", 48'h77, 48'h88, 2'd1, 0, 1, 0);

        // random frames, biased toward learned addresses for hits and drops
        for (int f = 0; f < 20; f++) begin
            sa  = {16'($urandom), 32'($urandom)};
            src = PW'($urandom_range(0, PN - 1));
            if (learned.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, learned.size() - 1);
                da = learned[idx];
                da[40] = 1'b0;
                if ($urandom_range(0, 1) == 1) src = lsrc[idx];
            end else begin
                da = {16'($urandom), 32'($urandom)};
            end
            learned.push_back(sa);
            lsrc.push_back(src);
            do_frame($sformatf("rand%0d", f), da, sa, src, $urandom_range(0, 2),
                     $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
